bin_maxpool2x2: RTL and testbench

- Downstream stage of the binary 3x3 convolution engine.
- Reads the binarized feature maps the convolution writes to output SRAM and applies a 2x2, stride-2 max-pool; for binary data this is a logical OR.
- Writes the pooled maps, each with a header, to a second SRAM.
- Uses the same run/busy control and the same SRAM interface timing as the convolution engine, so the top level can chain the two.

---
 rtl/bin_maxpool2x2.sv | 195 +++++++++++++++++++
 tb/tb_bin_maxpool2x2.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bin_maxpool2x2.sv
// Binary 2x2 stride-2 max-pool over a stream of headed feature maps.
// Reads maps from the convolution output SRAM, ORs each 2x2 window and
// writes the pooled maps, each with a header, followed by a terminator word.
module bin_maxpool2x2 #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MAX_DIM = 14
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic              pool_err,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [DATA_W-1:0] sram_dut_read_data,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              dut_sram_write_enable
);

  localparam int unsigned N_W = 5;
  localparam int unsigned R_W = 4;
  localparam logic [DATA_W-1:0] TERM_WORD = DATA_W'(16'h00FF);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    ROWA,
    ROWB,
    WRPOOL,
    WRHDR,
    WRTERM
  } state_t;

  state_t            state_q, state_d;
  logic              hdr_phase_q, hdr_phase_d;
  logic              busy_d, err_d;
  logic [ADDR_W-1:0] rd_addr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;
  logic              we_d;
  logic [N_W-1:0]    n_q, n_d;
  logic [R_W-1:0]    r_q, r_d;
  logic [DATA_W-1:0] a_q, a_d;

  logic [N_W-1:0]    hdr_n;
  logic              hdr_is_term;
  logic              hdr_legal;
  logic [DATA_W-1:0] row_mask;
  logic [DATA_W-1:0] vert;
  logic [DATA_W-1:0] pooled;
  logic              pool_last;

  // Header decode straight off the read data bus
  assign hdr_n       = sram_dut_read_data[N_W-1:0];
  assign hdr_is_term = (sram_dut_read_data == TERM_WORD);
  assign hdr_legal   = (sram_dut_read_data[DATA_W-1:N_W] == '0) && !hdr_n[0] &&
                       (hdr_n >= N_W'(2)) && (32'(hdr_n) <= MAX_DIM);

  // Columns at or beyond N are junk and must not reach the pool
  always_comb begin
    row_mask = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      row_mask[i] = (i < int'(n_q));
    end
  end

  assign vert = a_q | (sram_dut_read_data & row_mask);

  // Horizontal pair-OR of the vertically combined row pair
  always_comb begin
    pooled = '0;
    for (int j = 0; j < int'(DATA_W / 2); j++) begin
      pooled[j] = vert[2*j] | vert[2*j+1];
    end
  end

  assign pool_last = ((r_q + R_W'(1)) == R_W'(n_q[N_W-1:1]));

  // State and datapath registers; reset aborts any run in progress
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q                <= IDLE;
      hdr_phase_q            <= 1'b0;
      dut_busy               <= 1'b0;
      pool_err               <= 1'b0;
      dut_sram_read_address  <= '0;
      wr_ptr_q               <= '0;
      dut_sram_write_address <= '0;
      dut_sram_write_data    <= '0;
      dut_sram_write_enable  <= 1'b0;
      n_q                    <= '0;
      r_q                    <= '0;
      a_q                    <= '0;
    end else begin
      state_q                <= state_d;
      hdr_phase_q            <= hdr_phase_d;
      dut_busy               <= busy_d;
      pool_err               <= err_d;
      dut_sram_read_address  <= rd_addr_d;
      wr_ptr_q               <= wr_ptr_d;
      dut_sram_write_address <= wr_addr_d;
      dut_sram_write_data    <= wr_data_d;
      dut_sram_write_enable  <= we_d;
      n_q                    <= n_d;
      r_q                    <= r_d;
      a_q                    <= a_d;
    end
  end

  // Next-state logic; a write is staged here so its strobe is seen during the WR* state
  always_comb begin
    state_d     = state_q;
    hdr_phase_d = hdr_phase_q;
    busy_d      = dut_busy;
    err_d       = pool_err;
    rd_addr_d   = dut_sram_read_address;
    wr_ptr_d    = wr_ptr_q;
    wr_addr_d   = dut_sram_write_address;
    wr_data_d   = dut_sram_write_data;
    we_d        = 1'b0;
    n_d         = n_q;
    r_d         = r_q;
    a_d         = a_q;

    case (state_q)
      IDLE: begin
        if (dut_run) begin
          state_d     = HDR;
          hdr_phase_d = 1'b0;
          busy_d      = 1'b1;
          err_d       = 1'b0;
          rd_addr_d   = '0;
          wr_ptr_d    = '0;
        end
      end
      HDR: begin
        if (!hdr_phase_q) begin
          hdr_phase_d = 1'b1;
        end else begin
          hdr_phase_d = 1'b0;
          wr_addr_d   = wr_ptr_q;
          wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
          we_d        = 1'b1;
          if (hdr_is_term || !hdr_legal) begin
            err_d     = !hdr_is_term;
            wr_data_d = TERM_WORD;
            state_d   = WRTERM;
          end else begin
            n_d       = hdr_n;
            r_d       = '0;
            rd_addr_d = dut_sram_read_address + ADDR_W'(1);
            wr_data_d = DATA_W'(hdr_n[N_W-1:1]);
            state_d   = WRHDR;
          end
        end
      end
      WRHDR: begin
        rd_addr_d = dut_sram_read_address + ADDR_W'(1);
        state_d   = ROWA;
      end
      ROWA: begin
        a_d     = sram_dut_read_data & row_mask;
        state_d = ROWB;
      end
      ROWB: begin
        rd_addr_d = dut_sram_read_address + ADDR_W'(1);
        wr_addr_d = wr_ptr_q;
        wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
        wr_data_d = pooled;
        we_d      = 1'b1;
        state_d   = WRPOOL;
      end
      WRPOOL: begin
        r_d = r_q + R_W'(1);
        if (pool_last) begin
          hdr_phase_d = 1'b0;
          state_d     = HDR;
        end else begin
          rd_addr_d = dut_sram_read_address + ADDR_W'(1);
          state_d   = ROWA;
        end
      end
      WRTERM: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bin_maxpool2x2.sv
// Scoreboard bench for bin_maxpool2x2 with directed input streams.
module tb_bin_maxpool2x2;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned MAX_DIM = 14;

  logic              clk = 1'b0;
  logic              reset_b;
  logic              dut_run;
  logic              dut_busy;
  logic              pool_err;
  logic [ADDR_W-1:0] dut_sram_read_address;
  logic [DATA_W-1:0] sram_dut_read_data;
  logic [ADDR_W-1:0] dut_sram_write_address;
  logic [DATA_W-1:0] dut_sram_write_data;
  logic              dut_sram_write_enable;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               exp_q[$];
  int                n_cmp   = 0;
  int                n_bad   = 0;
  int                wr_seen = 0;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  bin_maxpool2x2 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MAX_DIM(MAX_DIM)
  ) dut (
    .clk                   (clk),
    .reset_b               (reset_b),
    .dut_run               (dut_run),
    .dut_busy              (dut_busy),
    .pool_err              (pool_err),
    .dut_sram_read_address (dut_sram_read_address),
    .sram_dut_read_data    (sram_dut_read_data),
    .dut_sram_write_address(dut_sram_write_address),
    .dut_sram_write_data   (dut_sram_write_data),
    .dut_sram_write_enable (dut_sram_write_enable)
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM model
  always @(posedge clk) sram_dut_read_data <= mem[dut_sram_read_address];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every write strobe is matched against the scoreboard head
  always @(negedge clk) begin
    wr_t e;
    if (dut_sram_write_enable === 1'b1) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 dut_sram_write_address, dut_sram_write_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(dut_sram_write_address), 32'(e.addr));
        check("wr_data", 32'(dut_sram_write_data), 32'(e.data));
      end
    end
  end

  // Pulse run, optionally re-pulse while busy, then wait for the run to end
  task automatic run_stream(input string nm, input bit poke);
    int cyc;
    @(negedge clk) dut_run = 1'b1;
    @(negedge clk) dut_run = 1'b0;
    check({nm, "_busy_rise"}, 32'(dut_busy), 32'd1);
    cyc = 0;
    while (dut_busy === 1'b1 && cyc < 2000) begin
      @(negedge clk);
      dut_run = (poke && cyc == 6);
      cyc++;
    end
    dut_run = 1'b0;
    check({nm, "_busy_fall"}, 32'(dut_busy), 32'd0);
    check({nm, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_busy"}, 32'(dut_busy), 32'd0);
    check({nm, "_err"}, 32'(pool_err), 32'd0);
    check({nm, "_raddr"}, 32'(dut_sram_read_address), 32'd0);
    check({nm, "_waddr"}, 32'(dut_sram_write_address), 32'd0);
    check({nm, "_wdata"}, 32'(dut_sram_write_data), 32'd0);
    check({nm, "_we"}, 32'(dut_sram_write_enable), 32'd0);
  endtask

  task automatic load_2x2();
    mem[0] = 16'd2;
    mem[1] = 16'h0001;
    mem[2] = 16'h0000;
    mem[3] = 16'h00FF;
    expect_wr(12'd0, 16'h0001);
    expect_wr(12'd1, 16'h0001);
    expect_wr(12'd2, 16'h00FF);
  endtask

  initial begin
    int start;
    int cyc;
    reset_b = 1'b0;
    dut_run = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset_b = 1'b1;
    @(negedge clk);

    // Empty stream
    mem[0] = 16'h00FF;
    expect_wr(12'd0, 16'h00FF);
    run_stream("empty", 1'b0);
    check("empty_err", 32'(pool_err), 32'd0);

    // Single 2x2 image
    load_2x2();
    run_stream("img2", 1'b0);

    // 8x8 checkerboard, with a run pulse while busy that must be ignored
    mem[0] = 16'd8;
    for (int r = 1; r <= 8; r++) mem[r] = (r % 2 == 1) ? 16'h0055 : 16'h00AA;
    mem[9] = 16'h00FF;
    expect_wr(12'd0, 16'd4);
    for (int r = 1; r <= 4; r++) expect_wr(12'(r), 16'h000F);
    expect_wr(12'd5, 16'h00FF);
    run_stream("chk8", 1'b1);

    // 14x14 all-ones then 10x10 all-zeros with junk above column N
    mem[0] = 16'd14;
    for (int r = 1; r <= 14; r++) mem[r] = 16'hFFFF;
    mem[15] = 16'd10;
    for (int r = 16; r <= 25; r++) mem[r] = 16'hFC00;
    mem[26] = 16'h00FF;
    expect_wr(12'd0, 16'd7);
    for (int r = 1; r <= 7; r++) expect_wr(12'(r), 16'h007F);
    expect_wr(12'd8, 16'd5);
    for (int r = 9; r <= 13; r++) expect_wr(12'(r), 16'h0000);
    expect_wr(12'd14, 16'h00FF);
    run_stream("b2b", 1'b0);
    check("b2b_err", 32'(pool_err), 32'd0);

    // Illegal header, then a clean run clears the error
    mem[0] = 16'h0007;
    expect_wr(12'd0, 16'h00FF);
    run_stream("illegal", 1'b0);
    check("illegal_err", 32'(pool_err), 32'd1);
    load_2x2();
    run_stream("recover", 1'b0);
    check("recover_err", 32'(pool_err), 32'd0);

    // Reset in the middle of ROWB on a 10x10 run
    mem[0] = 16'd10;
    for (int r = 1; r <= 10; r++) mem[r] = 16'hFFFF;
    mem[11] = 16'h00FF;
    expect_wr(12'd0, 16'd5);
    expect_wr(12'd1, 16'h001F);
    expect_wr(12'd2, 16'h001F);
    start = wr_seen;
    @(negedge clk) dut_run = 1'b1;
    @(negedge clk) dut_run = 1'b0;
    cyc = 0;
    while (wr_seen < start + 3 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("rst_trigger", 32'(wr_seen - start), 32'd3);
    @(posedge clk);
    #2 reset_b = 1'b0;
    #1;
    check_reset_outputs("midrst");
    check("midrst_pending", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_busy", 32'(dut_busy), 32'd0);
    load_2x2();
    run_stream("restart", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
